pattern_player: RTL and testbench
=================================

PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 Parameter SEQ_W, default 6: sequence-select width; NUM_SEQ = 2**SEQ_W sequences.
REQ-002 Parameter STEP_W, default 4: step-index width; LEN = 2**STEP_W steps per sequence.
REQ-003 Parameter RATE_W, default 3: rate-select width; rates 0..2**RATE_W-1.
REQ-004 Parameter DIV_BASE, default 25_000_000: step period in clocks at rate 0; minimum legal value 2**RATE_W.
REQ-005 CLK_50  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 seq_up, seq_dn  in  1 each  debounced level inputs; each rising edge is one select event.
REQ-008 rate_up, rate_dn  in  1 each  debounced level inputs; each rising edge is one rate event.
REQ-009 run  in  1  level; 1 = divider counts, 0 = pause with all state held.
REQ-010 mode  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 hold.
REQ-011 rom_addr  out  SEQ_W+STEP_W  registered {seq_num, step}; drives the pattern ROM address.
REQ-012 step_tick  out  1  one-cycle pulse in the cycle rom_addr takes a new value.
REQ-013 seq_num  out  SEQ_W; rate_num  out  RATE_W; done  out  1 (one-shot complete); dir  out  1 (1 = descending).

Function
REQ-014 Edge detect: event = input & ~prev, with prev registered per input; a level held high produces exactly one event.
REQ-015 rate_num: up event +1, saturating at 2**RATE_W-1; down event -1, saturating at 0; simultaneous up and down events leave it unchanged.
REQ-016 Step period: PERIOD = DIV_BASE >> rate_num clocks; the divider counts 0..PERIOD-1 while run=1, and the internal tick asserts on the terminal count, then the counter returns to 0.
REQ-017 Any rate_num change resets the divider counter to 0 in the same cycle; step is unaffected.
REQ-018 seq_num: up event +1 and down event -1, both wrapping modulo NUM_SEQ; simultaneous up and down events leave it unchanged.
REQ-019 Any seq_num change sets step=0, dir=0, done=0 and divider=0, and updates rom_addr and pulses step_tick one cycle after the event.
REQ-020 Loop mode: on each tick, step = (step+1) mod LEN; dir is held at 0.
REQ-021 Ping-pong mode: step moves one position per tick in the direction given by dir; at step LEN-1 with dir=0, dir becomes 1 and step becomes LEN-2; at step 0 with dir=1, dir becomes 0 and step becomes 1; each endpoint is emitted once per pass.
REQ-022 One-shot mode: step increments per tick until LEN-1; the tick that lands on LEN-1 sets done=1; while done=1, ticks are ignored and step_tick stays low.
REQ-023 Hold mode: ticks are ignored; step, dir and rom_addr are frozen; step_tick stays low.
REQ-024 Any change of the mode input clears done; entering loop mode forces dir=0; step keeps its value.
REQ-025 rom_addr and step_tick update one cycle after the tick or event that causes them (registered, latency 1).
REQ-026 run=0 freezes the divider; tick, step, rom_addr and step_tick are all held; seq and rate events are still accepted.
REQ-027 A seq event and a tick in the same cycle: the seq event wins (REQ-019) and the tick is discarded.

Reset
REQ-028 While reset=1 at a clock edge: seq_num=0, rate_num=0, step=0, dir=0, done=0, divider=0, rom_addr=0, step_tick=0.
REQ-029 Edge-detect prev registers reset to 1, so an input held high through reset produces no event.
REQ-030 reset asserted mid-sequence overrides all same-cycle events and ticks.

Structure
REQ-031 Package pattern_pkg holds the mode encoding (loop, ping-pong, one-shot, hold) and the default DIV_BASE.
REQ-032 A sub-module rate_divider (inputs run, rate_num, restart; output tick) implements REQ-016 and REQ-017.

Verification
Bench parameters for all scenarios: SEQ_W=2, STEP_W=2, RATE_W=2, DIV_BASE=8.
REQ-033 Loop mode, run=1, rate 0 -> step_tick every 8 clocks; rom_addr sequence 1,2,3,0,1.
REQ-034 Ping-pong mode, seq 1 -> rom_addr 4,5,6,7,6,5,4,5; dir=1 exactly while descending.
REQ-035 One-shot mode -> rom_addr 1,2,3; done=1 on the same cycle rom_addr becomes 3; no further step_tick over 40 clocks; a mode change to loop clears done.
REQ-036 Three rate_up pulses, then one more -> rate_num=3, stays 3; step_tick period becomes 1 clock; rate_dn and rate_up asserted in the same cycle -> rate_num unchanged.
REQ-037 seq_dn at seq 0, mid-step 2 -> seq_num=3, rom_addr=12 one cycle later with step_tick=1; a seq event coinciding with a tick yields rom_addr=12, not 13.
REQ-038 run=0 for 20 clocks, then run=1 -> no step_tick during the pause and divider phase preserved; reset pulse at step 2 -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared encodings and defaults for the pattern player.
package pattern_pkg;

  typedef enum logic [1:0] {
    ModeLoop     = 2'b00,
    ModePingPong = 2'b01,
    ModeOneShot  = 2'b10,
    ModeHold     = 2'b11
  } mode_e;

  // One step per half second on a 50 MHz clock at rate 0.
  localparam int unsigned DefaultDivBase = 25_000_000;

endpackage

// File: rtl/rate_divider.sv
// Step-rate divider: period DIV_BASE >> rate_num clocks, one-cycle tick on terminal count.
module rate_divider
  import pattern_pkg::*;
#(
  parameter int unsigned RATE_W   = 3,
  parameter int unsigned DIV_BASE = DefaultDivBase
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [RATE_W-1:0] rate_num,
  input  logic              restart,
  output logic              tick
);

  localparam int unsigned CntW = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     period;
  logic            terminal;

  always_comb begin
    period   = DIV_BASE >> rate_num;
    // >= guards against a count left above the new terminal value.
    terminal = (32'(cnt_q) >= (period - 32'd1));
    tick     = run && !restart && terminal;
    cnt_d    = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = terminal ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_player.sv
// Pattern ROM address sequencer: selectable sequence, step rate and playback mode.
module pattern_player
  import pattern_pkg::*;
#(
  parameter int unsigned SEQ_W    = 6,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned RATE_W   = 3,
  parameter int unsigned DIV_BASE = DefaultDivBase
) (
  input  logic                    CLK_50,
  input  logic                    reset,
  input  logic                    seq_up,
  input  logic                    seq_dn,
  input  logic                    rate_up,
  input  logic                    rate_dn,
  input  logic                    run,
  input  logic [1:0]              mode,
  output logic [SEQ_W+STEP_W-1:0] rom_addr,
  output logic                    step_tick,
  output logic [SEQ_W-1:0]        seq_num,
  output logic [RATE_W-1:0]       rate_num,
  output logic                    done,
  output logic                    dir
);

  localparam logic [STEP_W-1:0] LastStep   = '1;
  localparam logic [STEP_W-1:0] PenultStep = STEP_W'(2**STEP_W - 2);
  localparam logic [RATE_W-1:0] RateMax    = '1;

  // Bit order: seq_up, seq_dn, rate_up, rate_dn.
  logic [3:0] btn, prev_q, ev;

  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic [RATE_W-1:0]       rate_q, rate_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic                    dir_q, dir_d;
  logic                    done_q, done_d;
  logic [1:0]              mode_q;
  logic [SEQ_W+STEP_W-1:0] addr_q, addr_d;
  logic                    tick_q, advance;

  logic  seq_change, rate_change, mode_change, div_tick;
  mode_e mode_cur;

  assign btn      = {seq_up, seq_dn, rate_up, rate_dn};
  assign ev       = btn & ~prev_q;
  assign mode_cur = mode_e'(mode);

  always_comb begin
    rate_d = rate_q;
    if (ev[1] && !ev[0] && (rate_q != RateMax)) begin
      rate_d = rate_q + RATE_W'(1);
    end else if (ev[0] && !ev[1] && (rate_q != '0)) begin
      rate_d = rate_q - RATE_W'(1);
    end
    rate_change = (rate_d != rate_q);
  end

  always_comb begin
    seq_d = seq_q;
    if (ev[3] && !ev[2]) begin
      seq_d = seq_q + SEQ_W'(1);
    end else if (ev[2] && !ev[3]) begin
      seq_d = seq_q - SEQ_W'(1);
    end
    seq_change = (seq_d != seq_q);
  end

  assign mode_change = (mode != mode_q);

  rate_divider #(
    .RATE_W   (RATE_W),
    .DIV_BASE (DIV_BASE)
  ) u_rate_divider (
    .clk      (CLK_50),
    .reset    (reset),
    .run      (run),
    .rate_num (rate_q),
    .restart  (seq_change | rate_change),
    .tick     (div_tick)
  );

  always_comb begin
    step_d  = step_q;
    dir_d   = dir_q;
    done_d  = done_q;
    advance = 1'b0;
    if (seq_change) begin
      // A selection change restarts the pattern and overrides any same-cycle tick.
      step_d  = '0;
      dir_d   = 1'b0;
      done_d  = 1'b0;
      advance = 1'b1;
    end else begin
      if (mode_change) begin
        done_d = 1'b0;
      end
      if (mode_cur == ModeLoop) begin
        dir_d = 1'b0;
      end
      if (div_tick) begin
        case (mode_cur)
          ModeLoop: begin
            step_d  = step_q + STEP_W'(1);
            advance = 1'b1;
          end
          ModePingPong: begin
            advance = 1'b1;
            if (!dir_q) begin
              if (step_q == LastStep) begin
                dir_d  = 1'b1;
                step_d = PenultStep;
              end else begin
                step_d = step_q + STEP_W'(1);
              end
            end else begin
              if (step_q == '0) begin
                dir_d  = 1'b0;
                step_d = STEP_W'(1);
              end else begin
                step_d = step_q - STEP_W'(1);
              end
            end
          end
          ModeOneShot: begin
            if (!done_d) begin
              if (step_q != LastStep) begin
                step_d  = step_q + STEP_W'(1);
                advance = 1'b1;
              end
              if ((step_q == PenultStep) || (step_q == LastStep)) begin
                done_d = 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
    addr_d = {seq_d, step_d};
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      // High reset value keeps a button held through reset from firing.
      prev_q <= 4'b1111;
      seq_q  <= '0;
      rate_q <= '0;
      step_q <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      mode_q <= mode;
      addr_q <= '0;
      tick_q <= 1'b0;
    end else begin
      prev_q <= btn;
      seq_q  <= seq_d;
      rate_q <= rate_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      done_q <= done_d;
      mode_q <= mode;
      addr_q <= addr_d;
      tick_q <= advance;
    end
  end

  assign rom_addr  = addr_q;
  assign step_tick = tick_q;
  assign seq_num   = seq_q;
  assign rate_num  = rate_q;
  assign done      = done_q;
  assign dir       = dir_q;

endmodule

// File: tb/tb_pattern_player.sv
// Directed self-checking bench for pattern_player (SEQ_W=2, STEP_W=2, RATE_W=2, DIV_BASE=8).
module tb_pattern_player;

  logic       clk = 1'b0;
  logic       reset, seq_up, seq_dn, rate_up, rate_dn, run;
  logic [1:0] mode;
  logic [3:0] rom_addr;
  logic       step_tick;
  logic [1:0] seq_num;
  logic [1:0] rate_num;
  logic       done, dir;

  int checks   = 0;
  int failures = 0;

  pattern_player #(
    .SEQ_W    (2),
    .STEP_W   (2),
    .RATE_W   (2),
    .DIV_BASE (8)
  ) dut (
    .CLK_50    (clk),
    .reset     (reset),
    .seq_up    (seq_up),
    .seq_dn    (seq_dn),
    .rate_up   (rate_up),
    .rate_dn   (rate_dn),
    .run       (run),
    .mode      (mode),
    .rom_addr  (rom_addr),
    .step_tick (step_tick),
    .seq_num   (seq_num),
    .rate_num  (rate_num),
    .done      (done),
    .dir       (dir)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input logic [1:0] m);
    @(negedge clk);
    reset = 1'b1; mode = m; run = 1'b1;
    seq_up = 1'b0; seq_dn = 1'b0; rate_up = 1'b0; rate_dn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns the number of negedges until step_tick is seen, 0 if the budget expires.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (step_tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_seq(input logic up, input logic dn);
    @(negedge clk);
    seq_up = up; seq_dn = dn;
    @(negedge clk);
    seq_up = 1'b0; seq_dn = 1'b0;
  endtask

  task automatic pulse_rate(input logic up, input logic dn);
    @(negedge clk);
    rate_up = up; rate_dn = dn;
    @(negedge clk);
    rate_up = 1'b0; rate_dn = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(2'b00);
    checks++;
    if ({rom_addr, step_tick, seq_num, rate_num, done, dir} !== 11'b0) begin
      failures++;
      $display("FAIL reset_state: got addr=%0d tick=%0b seq=%0d rate=%0d done=%0b dir=%0b, want all 0",
               rom_addr, step_tick, seq_num, rate_num, done, dir);
    end
  endtask

  task automatic test_loop;
    int n;
    int exp_addr[5] = '{1, 2, 3, 0, 1};
    apply_reset(2'b00);
    for (int i = 0; i < 5; i++) begin
      wait_tick(20, n);
      checks++;
      if (n != 8 || rom_addr !== 4'(exp_addr[i]) || dir !== 1'b0) begin
        failures++;
        $display("FAIL loop_step[%0d]: got addr=%0d gap=%0d dir=%0b, want addr=%0d gap=8 dir=0",
                 i, rom_addr, n, dir, exp_addr[i]);
      end
    end
  endtask

  task automatic test_pingpong;
    int n;
    int   exp_addr[7] = '{5, 6, 7, 6, 5, 4, 5};
    logic exp_dir[7]  = '{0, 0, 0, 1, 1, 1, 0};
    apply_reset(2'b01);
    pulse_seq(1'b1, 1'b0);
    checks++;
    if (seq_num !== 2'd1 || rom_addr !== 4'd4 || step_tick !== 1'b1 || dir !== 1'b0) begin
      failures++;
      $display("FAIL pp_select: got seq=%0d addr=%0d tick=%0b dir=%0b, want seq=1 addr=4 tick=1 dir=0",
               seq_num, rom_addr, step_tick, dir);
    end
    for (int i = 0; i < 7; i++) begin
      wait_tick(20, n);
      checks++;
      if (n != 8 || rom_addr !== 4'(exp_addr[i]) || dir !== exp_dir[i]) begin
        failures++;
        $display("FAIL pp_step[%0d]: got addr=%0d dir=%0b gap=%0d, want addr=%0d dir=%0b gap=8",
                 i, rom_addr, dir, n, exp_addr[i], exp_dir[i]);
      end
    end
  endtask

  task automatic test_oneshot;
    int n;
    int cnt;
    int   exp_addr[3] = '{1, 2, 3};
    logic exp_done[3] = '{0, 0, 1};
    apply_reset(2'b10);
    for (int i = 0; i < 3; i++) begin
      wait_tick(20, n);
      checks++;
      if (n != 8 || rom_addr !== 4'(exp_addr[i]) || done !== exp_done[i]) begin
        failures++;
        $display("FAIL os_step[%0d]: got addr=%0d done=%0b gap=%0d, want addr=%0d done=%0b gap=8",
                 i, rom_addr, done, n, exp_addr[i], exp_done[i]);
      end
    end
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (step_tick) cnt++;
    end
    checks++;
    if (cnt != 0 || rom_addr !== 4'd3 || done !== 1'b1) begin
      failures++;
      $display("FAIL os_idle: got ticks=%0d addr=%0d done=%0b, want ticks=0 addr=3 done=1",
               cnt, rom_addr, done);
    end
    mode = 2'b00;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || rom_addr !== 4'd3) begin
      failures++;
      $display("FAIL os_mode_clear: got done=%0b addr=%0d, want done=0 addr=3", done, rom_addr);
    end
    wait_tick(20, n);
    checks++;
    if (n == 0 || rom_addr !== 4'd0) begin
      failures++;
      $display("FAIL os_resume_loop: got addr=%0d gap=%0d, want addr=0 gap>0", rom_addr, n);
    end
  endtask

  task automatic test_rate;
    int exp_rate[3] = '{1, 2, 3};
    logic [3:0] exp_a;
    apply_reset(2'b00);
    for (int i = 0; i < 3; i++) begin
      pulse_rate(1'b1, 1'b0);
      checks++;
      if (rate_num !== 2'(exp_rate[i])) begin
        failures++;
        $display("FAIL rate_up[%0d]: got rate=%0d, want %0d", i, rate_num, exp_rate[i]);
      end
    end
    pulse_rate(1'b1, 1'b0);
    checks++;
    if (rate_num !== 2'd3) begin
      failures++;
      $display("FAIL rate_sat_hi: got rate=%0d, want 3", rate_num);
    end
    for (int i = 0; i < 4; i++) begin
      exp_a = {rom_addr[3:2], rom_addr[1:0] + 2'd1};
      @(negedge clk);
      checks++;
      if (step_tick !== 1'b1 || rom_addr !== exp_a) begin
        failures++;
        $display("FAIL rate_fast[%0d]: got tick=%0b addr=%0d, want tick=1 addr=%0d",
                 i, step_tick, rom_addr, exp_a);
      end
    end
    pulse_rate(1'b0, 1'b1);
    checks++;
    if (rate_num !== 2'd2) begin
      failures++;
      $display("FAIL rate_dn: got rate=%0d, want 2", rate_num);
    end
    pulse_rate(1'b1, 1'b1);
    checks++;
    if (rate_num !== 2'd2) begin
      failures++;
      $display("FAIL rate_both: got rate=%0d, want 2", rate_num);
    end
    // A level held high counts as one event.
    @(negedge clk);
    rate_dn = 1'b1;
    repeat (5) @(negedge clk);
    rate_dn = 1'b0;
    @(negedge clk);
    checks++;
    if (rate_num !== 2'd1) begin
      failures++;
      $display("FAIL rate_held: got rate=%0d, want 1", rate_num);
    end
  endtask

  task automatic test_seq;
    int n;
    apply_reset(2'b00);
    wait_tick(20, n);
    wait_tick(20, n);
    checks++;
    if (rom_addr !== 4'd2) begin
      failures++;
      $display("FAIL seq_pre: got addr=%0d, want 2", rom_addr);
    end
    repeat (3) @(negedge clk);
    pulse_seq(1'b0, 1'b1);
    checks++;
    if (seq_num !== 2'd3 || rom_addr !== 4'd12 || step_tick !== 1'b1) begin
      failures++;
      $display("FAIL seq_wrap_dn: got seq=%0d addr=%0d tick=%0b, want seq=3 addr=12 tick=1",
               seq_num, rom_addr, step_tick);
    end
    @(negedge clk);
    checks++;
    if (step_tick !== 1'b0) begin
      failures++;
      $display("FAIL seq_tick_width: got tick=%0b, want 0", step_tick);
    end
    pulse_seq(1'b1, 1'b0);
    checks++;
    if (seq_num !== 2'd0 || rom_addr !== 4'd0 || step_tick !== 1'b1) begin
      failures++;
      $display("FAIL seq_wrap_up: got seq=%0d addr=%0d tick=%0b, want seq=0 addr=0 tick=1",
               seq_num, rom_addr, step_tick);
    end
    // Place the next event on the same edge as the divider tick.
    repeat (6) @(negedge clk);
    pulse_seq(1'b0, 1'b1);
    checks++;
    if (seq_num !== 2'd3 || rom_addr !== 4'd12 || step_tick !== 1'b1) begin
      failures++;
      $display("FAIL seq_vs_tick: got seq=%0d addr=%0d tick=%0b, want seq=3 addr=12 tick=1",
               seq_num, rom_addr, step_tick);
    end
    wait_tick(20, n);
    checks++;
    if (n != 8 || rom_addr !== 4'd13) begin
      failures++;
      $display("FAIL seq_after_tick: got addr=%0d gap=%0d, want addr=13 gap=8", rom_addr, n);
    end
  endtask

  task automatic test_pause;
    int n;
    int cnt;
    apply_reset(2'b00);
    wait_tick(20, n);
    repeat (3) @(negedge clk);
    run = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_tick) cnt++;
    end
    checks++;
    if (cnt != 0 || rom_addr !== 4'd1) begin
      failures++;
      $display("FAIL pause_hold: got ticks=%0d addr=%0d, want ticks=0 addr=1", cnt, rom_addr);
    end
    run = 1'b1;
    wait_tick(20, n);
    checks++;
    if (n != 5 || rom_addr !== 4'd2) begin
      failures++;
      $display("FAIL pause_phase: got gap=%0d addr=%0d, want gap=5 addr=2", n, rom_addr);
    end
  endtask

  task automatic test_hold;
    int cnt;
    apply_reset(2'b11);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (step_tick) cnt++;
    end
    checks++;
    if (cnt != 0 || rom_addr !== 4'd0) begin
      failures++;
      $display("FAIL hold_frozen: got ticks=%0d addr=%0d, want ticks=0 addr=0", cnt, rom_addr);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    apply_reset(2'b01);
    pulse_seq(1'b1, 1'b0);
    pulse_rate(1'b1, 1'b0);
    wait_tick(20, n);
    wait_tick(20, n);
    checks++;
    if (rom_addr !== 4'd6 || rate_num !== 2'd1) begin
      failures++;
      $display("FAIL mid_pre: got addr=%0d rate=%0d, want addr=6 rate=1", rom_addr, rate_num);
    end
    @(negedge clk);
    reset = 1'b1; seq_up = 1'b1; rate_up = 1'b1;
    @(negedge clk);
    checks++;
    if ({rom_addr, step_tick, seq_num, rate_num, done, dir} !== 11'b0) begin
      failures++;
      $display("FAIL mid_reset: got addr=%0d tick=%0b seq=%0d rate=%0d done=%0b dir=%0b, want all 0",
               rom_addr, step_tick, seq_num, rate_num, done, dir);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seq_num !== 2'd0 || rate_num !== 2'd0) begin
      failures++;
      $display("FAIL held_through_reset: got seq=%0d rate=%0d, want seq=0 rate=0",
               seq_num, rate_num);
    end
    seq_up = 1'b0; rate_up = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mode = 2'b00;
    seq_up = 1'b0; seq_dn = 1'b0; rate_up = 1'b0; rate_dn = 1'b0;
    test_reset();
    test_loop();
    test_pingpong();
    test_oneshot();
    test_rate();
    test_seq();
    test_pause();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
